// File: rtl/ddr_arb_pkg.sv
// FSM encoding shared by the DDR command-port arbiter and anything that decodes its debug state.
package ddr_arb_pkg;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ARB   = 3'd1;
   localparam logic [2:0] ST_CMD   = 3'd2;
   localparam logic [2:0] ST_WDATA = 3'd3;
   localparam logic [2:0] ST_RDATA = 3'd4;

   // A burst owns the port from command presentation until its data phase ends.
   function automatic logic is_busy_state(input logic [2:0] st);
      return (st == ST_CMD) || (st == ST_WDATA) || (st == ST_RDATA);
   endfunction
endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping modulo NUM_REQ.
module rr_prio_pick #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic [ID_WIDTH-1:0] ptr_i,
   output logic [NUM_REQ-1:0]  onehot_o,
   output logic [ID_WIDTH-1:0] id_o,
   output logic                any_o
);
   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [ID_WIDTH:0]    idx;
   logic [ID_WIDTH:0]    off;
   logic [ID_WIDTH:0]    sum;

   always_comb begin
      dbl = {req_i, req_i};
      rot = '0;
      idx = '0;
      // rot[k] is the request k positions above the pointer, so bit 0 has top priority.
      for (int i = 0; i < NUM_REQ; i++) begin
         idx    = {1'b0, ptr_i} + (ID_WIDTH+1)'(i);
         rot[i] = dbl[idx];
      end
      off = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (rot[i]) off = (ID_WIDTH+1)'(i);
      end
      sum = off + {1'b0, ptr_i};
      if (sum >= (ID_WIDTH+1)'(NUM_REQ)) sum = sum - (ID_WIDTH+1)'(NUM_REQ);
      any_o = |req_i;
      id_o  = any_o ? sum[ID_WIDTH-1:0] : '0;
      onehot_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         onehot_o[i] = any_o && (id_o == ID_WIDTH'(i));
      end
   end
endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Round-robin owner of the DDR controller command port; one burst in flight, grant held through data.
module ddr_cmd_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 28,
   parameter int LEN_WIDTH  = 4,
   parameter int ID_WIDTH   = 2
) (
   input  logic                            core_clk,
   input  logic                            ddr_rstn,
   input  logic                            ddr_init_done,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0]              req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            cmd_valid,
   input  logic                            cmd_ready,
   output logic                            cmd_write,
   output logic [ADDR_WIDTH-1:0]           cmd_addr,
   output logic [LEN_WIDTH-1:0]            cmd_len,
   input  logic                            wr_burst_done,
   input  logic                            rd_burst_done,
   output logic [NUM_REQ-1:0]              grant_onehot,
   output logic [ID_WIDTH-1:0]             grant_id,
   output logic                            arb_busy,
   output logic [2:0]                      dbg_state,
   output logic [ID_WIDTH-1:0]             dbg_rr_ptr
);
   import ddr_arb_pkg::*;

   logic [2:0]            state_q, state_d;
   logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
   logic [NUM_REQ-1:0]    grant_oh_q, grant_oh_d;
   logic                  cmd_valid_q, cmd_valid_d;
   logic                  cmd_write_q, cmd_write_d;
   logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [LEN_WIDTH-1:0]  cmd_len_q, cmd_len_d;

   logic [NUM_REQ-1:0]    pick_oh;
   logic [ID_WIDTH-1:0]   pick_id;
   logic                  pick_any;
   logic                  win_write;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [LEN_WIDTH-1:0]  win_len;
   logic                  accept;

   rr_prio_pick #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
      .req_i    (req_valid),
      .ptr_i    (rr_ptr_q),
      .onehot_o (pick_oh),
      .id_o     (pick_id),
      .any_o    (pick_any)
   );

   always_comb begin
      win_write = 1'b0;
      win_addr  = '0;
      win_len   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_oh[i]) begin
            win_write = req_write[i];
            win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_len   = req_len[i*LEN_WIDTH +: LEN_WIDTH];
         end
      end
   end

   // Handshake: a command transfers on any edge where cmd_valid & cmd_ready; once raised, cmd_valid
   // and every cmd_* field stay frozen until that edge, and the owner sees req_ready for that cycle only.
   assign accept    = cmd_valid_q & cmd_ready;
   assign req_ready = {NUM_REQ{accept}} & grant_oh_q;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      grant_oh_d  = grant_oh_q;
      cmd_valid_d = cmd_valid_q;
      cmd_write_d = cmd_write_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_len_d   = cmd_len_q;
      case (state_q)
         ST_IDLE: if (ddr_init_done) state_d = ST_ARB;
         ST_ARB: begin
            if (!ddr_init_done) begin
               state_d = ST_IDLE;
            end else if (pick_any) begin
               state_d     = ST_CMD;
               grant_oh_d  = pick_oh;
               grant_id_d  = pick_id;
               cmd_valid_d = 1'b1;
               cmd_write_d = win_write;
               cmd_addr_d  = win_addr;
               cmd_len_d   = win_len;
            end
         end
         ST_CMD: begin
            if (accept) begin
               cmd_valid_d = 1'b0;
               rr_ptr_d    = (grant_id_q == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id_q + 1'b1;
               state_d     = cmd_write_q ? ST_WDATA : ST_RDATA;
            end
         end
         ST_WDATA: begin
            if (wr_burst_done) begin
               state_d    = ST_ARB;
               grant_oh_d = '0;
               grant_id_d = '0;
            end
         end
         ST_RDATA: begin
            if (rd_burst_done) begin
               state_d    = ST_ARB;
               grant_oh_d = '0;
               grant_id_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge core_clk or negedge ddr_rstn) begin
      if (!ddr_rstn) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         grant_oh_q  <= '0;
         cmd_valid_q <= 1'b0;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_len_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         grant_oh_q  <= grant_oh_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_write_q <= cmd_write_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_len_q   <= cmd_len_d;
      end
   end

   assign cmd_valid    = cmd_valid_q;
   assign cmd_write    = cmd_write_q;
   assign cmd_addr     = cmd_addr_q;
   assign cmd_len      = cmd_len_q;
   assign grant_onehot = grant_oh_q;
   assign grant_id     = grant_id_q;
   assign arb_busy     = is_busy_state(state_q);
   assign dbg_state    = state_q;
   assign dbg_rr_ptr   = rr_ptr_q;
endmodule
